// File: rtl/data_memory_mmio.sv
// data_memory_mmio: big-endian byte data memory with LED register and debounced switch MMIO
module data_memory_mmio #(
  parameter int MEM_BYTES = 2048,
  parameter int LED_W = 10,
  parameter int SW_W = 10,
  parameter int DEBOUNCE = 16
) (
  input logic clk,
  input logic rst,
  input logic [31:0] Address,
  input logic [31:0] DataWr,
  input logic DMIOWr,
  input logic DMRdEn,
  input logic [2:0] DMCtrl,
  input logic [SW_W-1:0] sw,
  output logic [31:0] DataRd,
  output logic RdValid,
  output logic Misaligned,
  output logic [LED_W-1:0] led
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};
  logic [1:0] region, sz;
  logic [AW-1:0] idx;
  logic ok_ctrl, mis, mem_ok, upd, unused;
  logic [7:0] b0, b1, b2, b3;
  logic [31:0] mem_rd, rd_data;
  logic [SW_W-1:0] sync1, sync2, stable;
  logic [CW-1:0] cnt;
  logic sw_evt;
  logic [LED_W-1:0] mask;
  assign region = Address[13:12];
  assign sz = DMCtrl[1:0];
  assign idx = Address[AW-1:0];
  assign ok_ctrl = sz != 2'b11 && !(DMCtrl[2] && DMCtrl[1]);
  assign mis = region == 2'd0 && ok_ctrl && ((sz == 2'd1 && Address[0]) || (sz == 2'd2 && Address[1:0] != 2'd0));
  assign mem_ok = ok_ctrl && !mis;
  assign b0 = mem[idx];
  assign b1 = mem[idx + AW'(1)];
  assign b2 = mem[idx + AW'(2)];
  assign b3 = mem[idx + AW'(3)];
  assign mem_rd = !mem_ok ? '0 :
                  sz == 2'd2 ? {b0, b1, b2, b3} :
                  sz == 2'd1 ? {{16{b0[7] & ~DMCtrl[2]}}, b0, b1} :
                  {{24{b0[7] & ~DMCtrl[2]}}, b0};
  assign rd_data = region == 2'd0 ? mem_rd :
                   region == 2'd1 ? 32'(led) :
                   region == 2'd2 ? (32'(stable) | {sw_evt, 31'b0}) : '0;
  assign upd = sync2 != stable && cnt == CW'(DEBOUNCE - 1);
  assign mask = DataWr[LED_W-1:0];
  assign unused = ^{Address, DataWr};
  always_ff @(posedge clk)
    if (!rst && DMIOWr && region == 2'd0 && mem_ok)
      for (int i = 0; i < 4; i++)
        if (i < (1 << sz)) mem[idx + AW'(i)] <= DataWr[8 * ((1 << sz) - 1 - i) +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      DataRd <= '0;
      RdValid <= 1'b0;
      Misaligned <= 1'b0;
      led <= '0;
      sync1 <= '0;
      sync2 <= '0;
      stable <= '0;
      cnt <= '0;
      sw_evt <= 1'b0;
    end else begin
      RdValid <= DMRdEn;
      Misaligned <= (DMIOWr || DMRdEn) && mis;
      if (DMRdEn) DataRd <= rd_data;
      if (DMIOWr && region == 2'd1) led <= mask;
      else if (DMIOWr && region == 2'd3)
        led <= Address[3:2] == 2'd0 ? led | mask :
               Address[3:2] == 2'd1 ? led & ~mask :
               Address[3:2] == 2'd2 ? led ^ mask : led;
      sync1 <= sw;
      sync2 <= sync1;
      cnt <= (sync1 != sync2 || sync2 == stable || upd) ? '0 : cnt + 1'b1;
      if (upd) stable <= sync2;
      sw_evt <= upd || (sw_evt && !(DMIOWr && region == 2'd2));
    end
  end
endmodule

// File: tb/tb_data_memory_mmio.sv
// tb_data_memory_mmio: randomized scoreboard bench against a behavioural memory/MMIO model
module tb_data_memory_mmio;
  localparam int MB = 2048;
  localparam int DB = 16;
  typedef struct packed {
    logic rv;
    logic mis;
    logic [9:0] led;
    logic [31:0] drd;
  } cyc_t;
  logic clk = 1'b0, rst = 1'b1, DMIOWr = 1'b0, DMRdEn = 1'b0;
  logic [31:0] Address = '0, DataWr = '0;
  logic [2:0] DMCtrl = '0;
  logic [9:0] sw = '0, swv = '0;
  logic [31:0] DataRd;
  logic RdValid, Misaligned;
  logic [9:0] led;
  logic [7:0] m [MB];
  logic [9:0] mled = '0, mstable = '0;
  logic mevt = 1'b0;
  logic [31:0] mdrd = '0;
  int since = 0;
  cyc_t cq[$];
  logic [31:0] dq[$];
  cyc_t e;
  logic [31:0] x;
  int checks = 0, fails = 0;
  data_memory_mmio #(.MEM_BYTES(MB), .LED_W(10), .SW_W(10), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .Address(Address), .DataWr(DataWr), .DMIOWr(DMIOWr),
    .DMRdEn(DMRdEn), .DMCtrl(DMCtrl), .sw(sw), .DataRd(DataRd), .RdValid(RdValid),
    .Misaligned(Misaligned), .led(led)
  );
  always #5 clk = ~clk;
  task automatic acc(input logic r, input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    int n, o;
    logic [1:0] rg;
    logic vld, bad;
    logic [31:0] v;
    cyc_t ce;
    @(negedge clk);
    rst = r; DMIOWr = wr; DMRdEn = rd; Address = a; DataWr = d; DMCtrl = c;
    if (swv != sw) since = 0;
    sw = swv;
    rg = a[13:12];
    o = int'(a[11:0]) % MB;
    n = (c[1:0] == 2'd0) ? 1 : (c[1:0] == 2'd1) ? 2 : 4;
    vld = c inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bad = rg == 2'd0 && vld && (o % n != 0);
    ce.rv = !r && rd;
    ce.mis = !r && (wr || rd) && bad;
    if (ce.rv) begin
      v = '0;
      if (rg == 2'd0 && vld && !bad) begin
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(m[(o + i) % MB]);
        if (!c[2] && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 1);
      end else if (rg == 2'd1) v = 32'(mled);
      else if (rg == 2'd2) v = {mevt, 21'd0, mstable};
      dq.push_back(v);
      mdrd = v;
    end
    if (r) begin
      mled = '0; mstable = '0; mevt = 1'b0; since = 0; mdrd = '0;
    end else begin
      if (wr && rg == 2'd0 && vld && !bad)
        for (int i = 0; i < n; i++) m[(o + i) % MB] = 8'(d >> (8 * (n - 1 - i)));
      if (wr && rg == 2'd1) mled = d[9:0];
      if (wr && rg == 2'd3)
        case (a[3:2])
          2'd0: mled = mled | d[9:0];
          2'd1: mled = mled & ~d[9:0];
          2'd2: mled = mled ^ d[9:0];
          default: ;
        endcase
      since++;
      if (since >= DB + 2 && sw != mstable) begin
        mstable = sw;
        mevt = 1'b1;
      end else if (wr && rg == 2'd2) mevt = 1'b0;
    end
    ce.led = mled;
    ce.drd = mdrd;
    cq.push_back(ce);
  endtask
  always @(posedge clk) begin
    #2;
    if (cq.size() > 0) begin
      e = cq.pop_front();
      checks++;
      if ({RdValid, Misaligned, led} !== {e.rv, e.mis, e.led}) begin
        fails++;
        $display("FAIL ctl t=%0t rv/mis/led got %b/%b/%h want %b/%b/%h", $time, RdValid, Misaligned, led, e.rv, e.mis, e.led);
      end
      checks++;
      if (DataRd !== e.drd) begin
        fails++;
        $display("FAIL hold t=%0t DataRd got %h want %h", $time, DataRd, e.drd);
      end
      if (RdValid) begin
        checks++;
        if (dq.size() == 0) begin
          fails++;
          $display("FAIL rdq t=%0t unexpected RdValid DataRd got %h want none", $time, DataRd);
        end else begin
          x = dq.pop_front();
          if (DataRd !== x) begin
            fails++;
            $display("FAIL rd t=%0t DataRd got %h want %h", $time, DataRd, x);
          end
        end
      end
    end
  end
  initial begin
    logic [31:0] r32, off;
    int k;
    for (int i = 0; i < MB; i++) m[i] = 8'h00;
    acc(1, 0, 0, 0, 0, 0);
    acc(1, 1, 1, 32'h1000, 32'h3FF, 3'd2);
    acc(1, 1, 1, 32'h0000, 32'hFFFFFFFF, 3'd2);
    acc(0, 0, 1, 32'h0000, 0, 3'd2);
    acc(0, 1, 0, 32'h100, 32'h11223344, 3'd2);
    acc(0, 0, 1, 32'h100, 0, 3'd2);
    acc(0, 0, 1, 32'h102, 0, 3'd1);
    acc(0, 0, 1, 32'h103, 0, 3'd4);
    acc(0, 0, 1, 32'h100, 0, 3'd0);
    acc(0, 1, 1, 32'h101, 32'hBEEF, 3'd1);
    acc(0, 0, 1, 32'h100, 0, 3'd2);
    acc(0, 1, 1, 32'h104, 32'h1234, 3'd3);
    acc(0, 0, 1, 32'h104, 0, 3'd2);
    acc(0, 1, 0, 32'h1000, 32'h0F0, 3'd2);
    acc(0, 1, 0, 32'h3000, 32'h00F, 3'd2);
    acc(0, 1, 0, 32'h3004, 32'h030, 3'd2);
    acc(0, 1, 1, 32'h3008, 32'h201, 3'd2);
    acc(0, 0, 1, 32'h1000, 0, 3'd7);
    acc(0, 0, 1, 32'h3000, 0, 3'd2);
    acc(0, 1, 0, 32'h200, 32'hAAAAAAAA, 3'd2);
    acc(0, 1, 1, 32'h200, 32'h55555555, 3'd2);
    acc(0, 0, 1, 32'hFFFF_C200, 0, 3'd2);
    acc(1, 1, 1, 32'h200, 32'h0, 3'd2);
    acc(1, 0, 0, 0, 0, 0);
    acc(0, 0, 1, 32'h200, 0, 3'd2);
    acc(0, 0, 1, 32'h1000, 0, 3'd2);
    swv = 10'h155;
    for (int i = 0; i < 5; i++) acc(0, 0, 1, 32'h2000, 0, 3'd2);
    swv = 10'h154;
    acc(0, 0, 1, 32'h2000, 0, 3'd2);
    swv = 10'h155;
    for (int i = 0; i < DB + 6; i++) acc(0, 0, 1, 32'h2000, 0, 3'd2);
    acc(0, 1, 0, 32'h2000, 0, 3'd2);
    acc(0, 0, 1, 32'h2000, 0, 3'd2);
    for (int i = 0; i < 1500; i++) begin
      r32 = $urandom();
      k = $urandom_range(0, 7);
      off = 32'($urandom_range(0, 31)) | ($urandom_range(0, 1) != 0 ? 32'h800 : 32'h0);
      acc($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          {r32[31:14], (k < 4) ? 2'd0 : 2'(k - 4), off[11:0]}, $urandom(), 3'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 3; i++) acc(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    checks++;
    if (dq.size() != 0 || cq.size() != 0) begin
      fails++;
      $display("FAIL drain pending reads got %0d want 0", dq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
